// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// pwm_bank : write-only register bank driving 16 pins off / high / shared PWM
// Rev 1.0 : initial release
// ============================================================================
module pwm_bank #(
    parameter int DIV   = 3000,
    parameter int CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr_en,
    input  logic [6:0]  reg_addr,
    input  logic [7:0]  reg_data,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [6:0]       C_ADDR_EN_LO   = 7'h00;
    localparam logic [6:0]       C_ADDR_EN_HI   = 7'h01;
    localparam logic [6:0]       C_ADDR_MODE_LO = 7'h02;
    localparam logic [6:0]       C_ADDR_MODE_HI = 7'h03;
    localparam logic [6:0]       C_ADDR_DUTY    = 7'h04;
    localparam logic [CNT_W-1:0] C_PRE_LAST     = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_PRE_ONE      = CNT_W'(1);
    localparam logic [7:0]       C_PWM_LAST     = 8'd254;
    localparam logic [7:0]       C_DUTY_FULL    = 8'd255;
    localparam int               C_PINS         = 16;

    logic [15:0]      r_en;
    logic [15:0]      r_mode;
    logic [7:0]       r_duty_shadow;
    logic [7:0]       r_duty_active;
    logic [CNT_W-1:0] r_pre_cnt;
    logic [7:0]       r_pwm_cnt;

    logic             w_tick;
    logic             w_wrap;
    logic             w_pwm_raw;
    logic [15:0]      w_pin_next;

    // Register file; unmapped addresses fall through the default arm untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en          <= '0;
            r_mode        <= '0;
            r_duty_shadow <= '0;
        end else if (reg_wr_en) begin
            case (reg_addr)
                C_ADDR_EN_LO:   r_en[7:0]     <= reg_data;
                C_ADDR_EN_HI:   r_en[15:8]    <= reg_data;
                C_ADDR_MODE_LO: r_mode[7:0]   <= reg_data;
                C_ADDR_MODE_HI: r_mode[15:8]  <= reg_data;
                C_ADDR_DUTY:    r_duty_shadow <= reg_data;
                default: ;
            endcase
        end
    end

    // With DIV=1 the prescaler is pinned at 0 and tick is permanently high.
    assign w_tick = (r_pre_cnt == C_PRE_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == C_PWM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + C_PRE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (w_wrap) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Shadow is copied only at the wrap, so a write landing on that same edge
    // is seen one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_active <= '0;
            period_start  <= 1'b0;
        end else begin
            period_start <= w_wrap;
            if (w_wrap) begin
                r_duty_active <= r_duty_shadow;
            end
        end
    end

    assign w_pwm_raw = (r_duty_active == C_DUTY_FULL) || (r_pwm_cnt < r_duty_active);

    genvar gi;
    generate
        for (gi = 0; gi < C_PINS; gi++) begin : g_pin
            assign w_pin_next[gi] = r_en[gi] ? (r_mode[gi] ? w_pwm_raw : 1'b1) : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= w_pin_next;
        end
    end

endmodule
`default_nettype wire
